ifetch_seq: RTL and testbench

// - Fetch sequencer for the combinational instruction memory: owns the fetch PC, drives the IM address.
// - Queues {pc, instr} pairs in a small FIFO; decode pops them via valid/ready handshake.
// - Handles branch/jump redirect (flush + reload), halt/drain and out-of-range PC fault.
// - Sits between the IM and the IF/ID register of the pipeline.

---
 rtl/ifetch_seq.sv | 140 ++++++++++++++
 tb/tb_ifetch_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_seq.sv
// Fetch sequencer: owns the fetch PC, reads the combinational IM and queues {pc, instr} pairs for decode.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned fetch/redirect PCs fault instead of being word-aligned.
module ifetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              im_pc,
  input  logic [31:0]              im_instr,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [31:0]              fetch_pc,
  output logic [31:0]              fetch_instr,
  output logic [$clog2(DEPTH):0]   fetch_count,
  output logic                     fault
);

  // state    | meaning
  // ST_RUN   | issuing fetches while the FIFO has room and the PC is legal
  // ST_HALT  | no new fetches; FIFO keeps draining
  // ST_FAULT | fetch stopped on an illegal PC; left only by redirect or reset

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0]   IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0]   IM_HI = IM_LO + (33'(IM_WORDS) << 2);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     fpc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            run;
  logic            pc_legal;
  logic            redir_misaligned;
  logic [31:0]     redir_target;
  logic            pop, pop_eff, push;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign pc_legal = ({1'b0, fpc} >= IM_LO) && ({1'b0, fpc} < IM_HI) && (fpc[1:0] == 2'b00);
  assign redir_misaligned = redirect_pc[1:0] != 2'b00;
  assign redir_target     = redirect_pc;
`else
  assign pc_legal = ({1'b0, fpc} >= IM_LO) && ({1'b0, fpc} < IM_HI);
  assign redir_misaligned = 1'b0;
  assign redir_target     = redirect_pc & 32'hFFFF_FFFC;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next-state logic; a redirect only changes state when leaving FAULT or entering it on misalignment
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (redir_misaligned)       state_nxt = ST_FAULT;
      else if (state == ST_FAULT) state_nxt = halt ? ST_HALT : ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt)           state_nxt = ST_HALT;
          else if (!pc_legal) state_nxt = ST_FAULT;
        end
        ST_HALT: begin
          if (!halt) state_nxt = ST_RUN;
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  // Output decode
  always_comb begin
    run   = (state == ST_RUN);
    fault = (state == ST_FAULT);
  end

  assign pop     = fetch_valid & fetch_ready;
  assign pop_eff = pop & ~redirect_valid;
  assign push    = run & ~halt & ~redirect_valid & pc_legal & ((count < FULL) | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc   <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fpc   <= redir_target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fpc  <= fpc + 32'd4;
        tail <= tail + PW'(1);
      end
      if (pop_eff) head <= head + PW'(1);
      case ({push, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= fpc;
      instr_mem[tail] <= im_instr;
    end
  end

  assign im_pc       = fpc;
  assign fetch_count = count;
  assign fetch_valid = (count != '0);
  assign fetch_pc    = fetch_valid ? pc_mem[head]    : 32'h0;
  assign fetch_instr = fetch_valid ? instr_mem[head] : 32'h0;

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: scoreboard of expected {pc, instr} heads plus inline state checks.
module tb_ifetch_seq;

  logic        clk;
  logic        reset;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic [1:0]  fetch_count;
  logic        fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ifetch_seq dut (
    .clk(clk), .reset(reset), .im_pc(im_pc), .im_instr(im_instr), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .fetch_count(fetch_count), .fault(fault)
  );

  // IM word k holds 32'h1000_0000 + k
  assign im_instr = 32'h1000_0000 + ((im_pc - 32'h0000_3000) >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'h1000_0000 + ((pc - 32'h0000_3000) >> 2);
    return e;
  endfunction

  task automatic do_reset(input logic rdy);
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = rdy;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
    checks++; if (fetch_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    checks++; if (fetch_pc !== 32'h0 || fetch_instr !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0/0", fetch_pc, fetch_instr); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (im_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_im_pc got %h want 00003000", im_pc); end
    reset = 1'b0;
    // streaming with ready=1: one new head per cycle, no gaps
    for (int i = 0; i < 4; i++) sb.push_back(mk(32'h0000_3000 + 32'(4 * i)));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (fetch_valid !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL stream_valid cycle %0d got %b want 1", c, fetch_valid);
      end else begin
        e = sb.pop_front();
        checks++;
        if (fetch_pc !== e.pc || fetch_instr !== e.instr) begin
          errors++; $display("FAIL stream_head got %h/%h want %h/%h", fetch_pc, fetch_instr, e.pc, e.instr);
        end
      end
      checks++; if (fetch_count !== 2'd1) begin errors++; $display("FAIL stream_count got %0d want 1", fetch_count); end
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++; if (im_pc !== 32'h0000_3008) begin errors++; $display("FAIL bp_hold_a got %h want 00003008", im_pc); end
    repeat (2) @(negedge clk);
    checks++; if (fetch_count !== 2'd2) begin errors++; $display("FAIL bp_count got %0d want 2", fetch_count); end
    checks++; if (im_pc !== 32'h0000_3008) begin errors++; $display("FAIL bp_hold_b got %h want 00003008", im_pc); end
    for (int i = 0; i < 3; i++) sb.push_back(mk(32'h0000_3000 + 32'(4 * i)));
    fetch_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fetch_valid !== 1'b1) begin
        errors++; $display("FAIL bp_valid step %0d got %b want 1", k, fetch_valid);
      end else begin
        e = sb.pop_front();
        checks++;
        if (fetch_pc !== e.pc || fetch_instr !== e.instr) begin
          errors++; $display("FAIL bp_order got %h/%h want %h/%h", fetch_pc, fetch_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    checks++; if (fetch_pc !== 32'h0000_300C) begin errors++; $display("FAIL bp_next got %h want 0000300c", fetch_pc); end
  endtask

  task automatic test_redirect;
    exp_t e;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++; if (fetch_count !== 2'd2) begin errors++; $display("FAIL redir_pre_count got %0d want 2", fetch_count); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fetch_valid !== 1'b0 || fetch_count !== 2'd0) begin errors++; $display("FAIL redir_flush got v=%b c=%0d want v=0 c=0", fetch_valid, fetch_count); end
    checks++; if (im_pc !== 32'h0000_3100) begin errors++; $display("FAIL redir_im_pc got %h want 00003100", im_pc); end
    sb.push_back(mk(32'h0000_3100));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== e.pc || fetch_instr !== e.instr) begin
      errors++; $display("FAIL redir_head got v=%b %h/%h want v=1 %h/%h", fetch_valid, fetch_pc, fetch_instr, e.pc, e.instr);
    end
  endtask

  task automatic test_fault;
    exp_t e;
    do_reset(1'b1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_6FFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fetch_count !== 2'd0 || im_pc !== 32'h0000_6FFC) begin errors++; $display("FAIL flt_load got c=%0d pc=%h want c=0 pc=00006ffc", fetch_count, im_pc); end
    sb.push_back(mk(32'h0000_6FFC));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== e.pc || fetch_instr !== e.instr) begin
      errors++; $display("FAIL flt_last_head got v=%b %h/%h want v=1 %h/%h", fetch_valid, fetch_pc, fetch_instr, e.pc, e.instr);
    end
    checks++; if (im_pc !== 32'h0000_7000 || fault !== 1'b0) begin errors++; $display("FAIL flt_edge got pc=%h f=%b want pc=00007000 f=0", im_pc, fault); end
    @(negedge clk);
    checks++; if (fault !== 1'b1 || fetch_count !== 2'd0) begin errors++; $display("FAIL flt_set got f=%b c=%0d want f=1 c=0", fault, fetch_count); end
    halt = 1'b1;
    repeat (3) @(negedge clk);
    halt = 1'b0;
    checks++; if (fault !== 1'b1 || im_pc !== 32'h0000_7000 || fetch_count !== 2'd0) begin
      errors++; $display("FAIL flt_sticky got f=%b pc=%h c=%0d want f=1 pc=00007000 c=0", fault, im_pc, fetch_count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b0 || im_pc !== 32'h0000_3000) begin errors++; $display("FAIL flt_clear got f=%b pc=%h want f=0 pc=00003000", fault, im_pc); end
    sb.push_back(mk(32'h0000_3000));
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== e.pc) begin errors++; $display("FAIL flt_resume got v=%b %h want v=1 %h", fetch_valid, fetch_pc, e.pc); end
    // just below the legal window
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2FFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (fault !== 1'b1 || fetch_count !== 2'd0) begin errors++; $display("FAIL flt_low got f=%b c=%0d want f=1 c=0", fault, fetch_count); end
  endtask

  task automatic test_halt;
    exp_t e;
    do_reset(1'b0);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    checks++; if (fetch_count !== 2'd1 || im_pc !== 32'h0000_3004) begin errors++; $display("FAIL halt_nopush got c=%0d pc=%h want c=1 pc=00003004", fetch_count, im_pc); end
    sb.push_back(mk(32'h0000_3000));
    e = sb.pop_front();
    checks++; if (fetch_pc !== e.pc || fetch_instr !== e.instr) begin errors++; $display("FAIL halt_head got %h/%h want %h/%h", fetch_pc, fetch_instr, e.pc, e.instr); end
    fetch_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fetch_count !== 2'd0 || fetch_valid !== 1'b0 || im_pc !== 32'h0000_3004) begin
      errors++; $display("FAIL halt_drain got c=%0d v=%b pc=%h want c=0 v=0 pc=00003004", fetch_count, fetch_valid, im_pc);
    end
    halt = 1'b0;
    @(negedge clk);
    checks++; if (fetch_count !== 2'd0) begin errors++; $display("FAIL halt_exit_lat got c=%0d want 0", fetch_count); end
    sb.push_back(mk(32'h0000_3004));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== e.pc) begin errors++; $display("FAIL halt_resume got v=%b %h want v=1 %h", fetch_valid, fetch_pc, e.pc); end
    // redirect while halted: PC loads, fetch waits for halt release
    halt = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3040;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (im_pc !== 32'h0000_3040 || fetch_count !== 2'd0 || fault !== 1'b0) begin
      errors++; $display("FAIL halt_redir got pc=%h c=%0d f=%b want pc=00003040 c=0 f=0", im_pc, fetch_count, fault);
    end
    halt = 1'b0;
    sb.push_back(mk(32'h0000_3040));
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== e.pc || fetch_instr !== e.instr) begin
      errors++; $display("FAIL halt_redir_resume got v=%b %h/%h want v=1 %h/%h", fetch_valid, fetch_pc, fetch_instr, e.pc, e.instr);
    end
  endtask

  task automatic test_align;
    exp_t e;
    do_reset(1'b1);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3002;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
    checks++; if (fault !== 1'b1 || im_pc !== 32'h0000_3002) begin errors++; $display("FAIL align_fault got f=%b pc=%h want f=1 pc=00003002", fault, im_pc); end
    repeat (2) @(negedge clk);
    checks++; if (fetch_count !== 2'd0 || fault !== 1'b1) begin errors++; $display("FAIL align_nopush got c=%0d f=%b want c=0 f=1", fetch_count, fault); end
`else
    checks++; if (fault !== 1'b0 || im_pc !== 32'h0000_3000) begin errors++; $display("FAIL align_force got f=%b pc=%h want f=0 pc=00003000", fault, im_pc); end
    sb.push_back(mk(32'h0000_3000));
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== e.pc || fetch_instr !== e.instr) begin
      errors++; $display("FAIL align_resume got v=%b %h/%h want v=1 %h/%h", fetch_valid, fetch_pc, fetch_instr, e.pc, e.instr);
    end
`endif
  endtask

  task automatic test_midreset;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (fetch_count !== 2'd0 || fetch_valid !== 1'b0 || im_pc !== 32'h0000_3000 || fetch_pc !== 32'h0) begin
      errors++; $display("FAIL async_reset got c=%0d v=%b pc=%h head=%h want c=0 v=0 pc=00003000 head=0", fetch_count, fetch_valid, im_pc, fetch_pc);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_fault();
    test_halt();
    test_align();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
